// File: rtl/booth_r4_seq.sv
// Iterative radix-4 (modified) Booth multiplier, signed or unsigned per operation.
// Two multiplier bits retire per clock; valid/ready handshakes on operands and product.
module booth_r4_seq #(
  parameter int WIDTH = 409
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c
);

  localparam int ITER  = (WIDTH + 2) / 2;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int MUL_W = 2 * ITER + 1;
  localparam int ACC_W = WIDTH + 3;
  localparam int PAD_W = 2 * ITER - WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH+1:0]   mcand_r;
  logic [ACC_W-1:0]   acc_r;
  logic [MUL_W-1:0]   mul_r;

  logic               accept_s;
  logic [WIDTH+1:0]   a_ext_s;
  logic [2*ITER-1:0]  b_ext_s;
  logic [ACC_W-1:0]   m_ext_s;
  logic [ACC_W-1:0]   m2_s;
  logic [ACC_W-1:0]   pp_s;
  logic [ACC_W-1:0]   sum_s;
  logic [ACC_W-1:0]   acc_nxt_s;
  logic [MUL_W-1:0]   mul_nxt_s;
  logic [2*WIDTH-1:0] c_nxt_s;

  // Signedness only matters at capture, so it is folded into the extended operands.
  assign a_ext_s   = {{2{a[WIDTH-1] & is_signed}}, a};
  assign b_ext_s   = {{PAD_W{b[WIDTH-1] & is_signed}}, b};
  assign accept_s  = in_valid & in_ready;
  assign out_valid = (state_r == ST_DONE);

  // Booth recoding of the low triplet, accumulate, then arithmetic shift right by two.
  always_comb begin
    m_ext_s = {mcand_r[WIDTH+1], mcand_r};
    m2_s    = {m_ext_s[ACC_W-2:0], 1'b0};
    case (mul_r[2:0])
      3'b001, 3'b010: pp_s = m_ext_s;
      3'b011:         pp_s = m2_s;
      3'b100:         pp_s = -m2_s;
      3'b101, 3'b110: pp_s = -m_ext_s;
      default:        pp_s = {ACC_W{1'b0}};
    endcase
    sum_s     = acc_r + pp_s;
    acc_nxt_s = {{2{sum_s[ACC_W-1]}}, sum_s[ACC_W-1:2]};
    mul_nxt_s = {sum_s[1:0], mul_r[MUL_W-1:2]};
    // Bit 0 of the multiplier register is the appended recoding bit, not product.
    c_nxt_s   = (2*WIDTH)'({acc_nxt_s, mul_nxt_s[MUL_W-1:1]});
  end

  // Next-state and in_ready; in_ready follows out_ready only while holding a result.
  always_comb begin
    state_s  = state_r;
    in_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_s = ST_BUSY;
        else          state_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (cnt_r == CNT_W'(1)) state_s = ST_DONE;
        else                    state_s = ST_BUSY;
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) state_s = ST_BUSY;
          else          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Operand capture, per-cycle iteration and result write on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      mcand_r <= {(WIDTH+2){1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      mul_r   <= {MUL_W{1'b0}};
      c       <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_BUSY: begin
          acc_r <= acc_nxt_s;
          mul_r <= mul_nxt_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) c <= c_nxt_s;
        end
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            mcand_r <= a_ext_s;
            mul_r   <= {b_ext_s, 1'b0};
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= CNT_W'(ITER);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
